// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths, requester ids and write-request type for the regfile write path
package regfile_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NREGS    = 1 << ADDR_W;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;

  localparam logic [ADDR_W-1:0] G0_ADDR = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regfile_wr_fifo.sv
// rtl/regfile_wr_fifo.sv - small synchronous FIFO holding pending register writes for one requester
module regfile_wr_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW:0]  wr_ptr;
  logic [PW:0]  rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign rdata = mem[rd_ptr[PW-1:0]];

  // Advance pointers on accepted push/pop; both in one cycle leaves occupancy unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + {{PW{1'b0}}, 1'b1};
      if (pop && !empty)
        rd_ptr <= rd_ptr + {{PW{1'b0}}, 1'b1};
    end
  end

  // Storage array; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[PW-1:0]] <= wdata;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter sharing the single register-file write port
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        in_valid,
  output logic [1:0]        in_ready,
  input  logic [ADDR_W-1:0] in_addr0,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [ADDR_W-1:0] in_addr1,
  input  logic [DATA_W-1:0] in_data1,
  input  logic              wr_hold,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [NREGS-1:0]  wr_sel,
  output logic              busy
);

  wr_req_t    req0, req1, head0, head1, gnt_req;
  logic [1:0] push, pop, full, empty;
  logic       rr;

  assign req0 = '{addr: in_addr0, data: in_data0};
  assign req1 = '{addr: in_addr1, data: in_data1};

  // Ready is purely the registered full flag; %g0 writes handshake but are dropped.
  assign in_ready        = ~full;
  assign push[REQ_ALU]   = in_valid[REQ_ALU]  & ~full[REQ_ALU]  & (in_addr0 != G0_ADDR);
  assign push[REQ_LOAD]  = in_valid[REQ_LOAD] & ~full[REQ_LOAD] & (in_addr1 != G0_ADDR);

  regfile_wr_fifo #(.W($bits(wr_req_t)), .DEPTH(FIFO_DEPTH)) u_fifo_alu (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push[REQ_ALU]),
    .wdata (req0),
    .pop   (pop[REQ_ALU]),
    .rdata (head0),
    .full  (full[REQ_ALU]),
    .empty (empty[REQ_ALU])
  );

  regfile_wr_fifo #(.W($bits(wr_req_t)), .DEPTH(FIFO_DEPTH)) u_fifo_load (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push[REQ_LOAD]),
    .wdata (req1),
    .pop   (pop[REQ_LOAD]),
    .rdata (head1),
    .full  (full[REQ_LOAD]),
    .empty (empty[REQ_LOAD])
  );

  // Grant: lone non-empty FIFO wins outright; contention resolved by rr; hold blocks all.
  always_comb begin
    pop = 2'b00;
    if (!wr_hold) begin
      if (!empty[REQ_ALU] && !empty[REQ_LOAD])
        pop[rr] = 1'b1;
      else if (!empty[REQ_ALU])
        pop[REQ_ALU] = 1'b1;
      else if (!empty[REQ_LOAD])
        pop[REQ_LOAD] = 1'b1;
    end
  end

  assign gnt_req = pop[REQ_LOAD] ? head1 : head0;

  // Registered write port; rr points at the requester that was not just served.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr      <= 1'b0;
      wr_en   <= 1'b0;
      wr_sel  <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (|pop) begin
      rr      <= pop[REQ_ALU];
      wr_en   <= 1'b1;
      wr_addr <= gnt_req.addr;
      wr_data <= gnt_req.data;
      wr_sel  <= {{(NREGS-1){1'b0}}, 1'b1} << gnt_req.addr;
    end else begin
      wr_en   <= 1'b0;
      wr_sel  <= '0;
    end
  end

  assign busy = (|(~empty)) | wr_en;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  localparam int D = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        in_valid;
  logic [1:0]        in_ready;
  logic [ADDR_W-1:0] in_addr0, in_addr1;
  logic [DATA_W-1:0] in_data0, in_data1;
  logic              wr_hold;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [NREGS-1:0]  wr_sel;
  logic              busy;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.FIFO_DEPTH(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr0 (in_addr0),
    .in_data0 (in_data0),
    .in_addr1 (in_addr1),
    .in_data1 (in_data1),
    .wr_hold  (wr_hold),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_sel   (wr_sel),
    .busy     (busy)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: two bounded queues, an alternating preference bit, and the last write.
  logic [36:0]       mq0[$], mq1[$];
  bit                m_rr, m_wr_en, model_ok;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;

  always @(posedge clk) begin
    bit r0, r1;
    int g;
    if (!rst_n) begin
      mq0.delete(); mq1.delete();
      m_rr = 0; m_wr_en = 0; m_addr = '0; m_data = '0;
      model_ok = 1;
    end else if (model_ok) begin
      r0 = (mq0.size() < D);
      r1 = (mq1.size() < D);
      g = -1;
      if (!wr_hold) begin
        if (mq0.size() > 0 && mq1.size() > 0) g = m_rr ? 1 : 0;
        else if (mq0.size() > 0) g = 0;
        else if (mq1.size() > 0) g = 1;
      end
      if (g == 0) begin
        {m_addr, m_data} = mq0.pop_front(); m_wr_en = 1; m_rr = 1;
      end else if (g == 1) begin
        {m_addr, m_data} = mq1.pop_front(); m_wr_en = 1; m_rr = 0;
      end else begin
        m_wr_en = 0;
      end
      if (in_valid[0] && r0 && in_addr0 != 0) mq0.push_back({in_addr0, in_data0});
      if (in_valid[1] && r1 && in_addr1 != 0) mq1.push_back({in_addr1, in_data1});
    end
  end

  logic [ADDR_W-1:0] wlog[$];

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [NREGS-1:0] exp_sel;
    if (model_ok) begin
      exp_sel = m_wr_en ? (32'd1 << m_addr) : 32'd0;
      chk("wr_en", 64'(wr_en), 64'(m_wr_en));
      chk("wr_sel", 64'(wr_sel), 64'(exp_sel));
      chk("wr_addr", 64'(wr_addr), 64'(m_addr));
      chk("wr_data", 64'(wr_data), 64'(m_data));
      chk("in_ready", 64'(in_ready), 64'({mq1.size() < D, mq0.size() < D}));
      chk("busy", 64'(busy), 64'(mq0.size() > 0 || mq1.size() > 0 || m_wr_en));
      if (wr_en) wlog.push_back(wr_addr);
    end
  end

  logic [36:0] p0[$], p1[$];

  task automatic step();
    @(negedge clk);
    in_valid = 2'b00;
    if (p0.size() > 0) begin
      in_valid[0] = 1'b1;
      {in_addr0, in_data0} = p0[0];
      if (in_ready[0]) void'(p0.pop_front());
    end
    if (p1.size() > 0) begin
      in_valid[1] = 1'b1;
      {in_addr1, in_data1} = p1[0];
      if (in_ready[1]) void'(p1.pop_front());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 2'b00; wr_hold = 1'b0;
    p0.delete(); p1.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [36:0] req(input int a);
    return {5'(a), 32'hA500_0000 | 32'(a)};
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 2'b00; wr_hold = 1'b0;
    in_addr0 = '0; in_data0 = '0; in_addr1 = '0; in_data1 = '0;

    // Reset held two cycles, then no write in the first cycle after release.
    repeat (2) @(negedge clk);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_sel", 64'(wr_sel), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd3);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_wr_en", 64'(wr_en), 64'd0);

    // Single ALU write: two cycles in to out.
    p0.push_back({5'd5, 32'hDEADBEEF});
    step();
    step();
    chk("t2_lat_wr_en_early", 64'(wr_en), 64'd0);
    step();
    chk("t2_wr_en", 64'(wr_en), 64'd1);
    chk("t2_wr_addr", 64'(wr_addr), 64'd5);
    chk("t2_wr_sel", 64'(wr_sel), 64'h0000_0020);
    chk("t2_wr_data", 64'(wr_data), 64'hDEADBEEF);
    step();
    chk("t2_wr_en_off", 64'(wr_en), 64'd0);

    // Both requesters streaming from reset: writes interleave 1..6.
    do_reset();
    #1 wlog.delete();
    foreach (p0[i]) ;
    p0.push_back(req(1)); p0.push_back(req(3)); p0.push_back(req(5));
    p1.push_back(req(2)); p1.push_back(req(4)); p1.push_back(req(6));
    repeat (12) step();
    #1;
    chk("t3_count", 64'(wlog.size()), 64'd6);
    for (int i = 0; i < 6 && i < wlog.size(); i++)
      chk($sformatf("t3_order%0d", i), 64'(wlog[i]), 64'(i + 1));

    // %g0 write: handshake completes, nothing is written.
    wlog.delete();
    p0.push_back({5'd0, 32'hFFFFFFFF});
    step();
    chk("t4_in_ready", 64'(in_ready[0]), 64'd1);
    repeat (4) begin
      step();
      chk("t4_busy", 64'(busy), 64'd0);
      chk("t4_wr_en", 64'(wr_en), 64'd0);
    end
    #1 chk("t4_no_write", 64'(wlog.size()), 64'd0);

    // Hold: FIFO fills with 7,8 and blocks 9; release drains in order.
    wr_hold = 1'b1;
    p0.push_back(req(7)); p0.push_back(req(8)); p0.push_back(req(9));
    repeat (4) step();
    chk("t5_ready_low", 64'(in_ready[0]), 64'd0);
    chk("t5_wr_en_held", 64'(wr_en), 64'd0);
    chk("t5_pending", 64'(p0.size()), 64'd1);
    wr_hold = 1'b0;
    repeat (8) step();
    #1;
    chk("t5_count", 64'(wlog.size()), 64'd3);
    for (int i = 0; i < 3 && i < wlog.size(); i++)
      chk($sformatf("t5_order%0d", i), 64'(wlog[i]), 64'(i + 7));

    // Both FIFOs full, then reset discards everything queued.
    wr_hold = 1'b1;
    p0.push_back(req(10)); p0.push_back(req(11));
    p1.push_back(req(12)); p1.push_back(req(13));
    repeat (4) step();
    chk("t6_full", 64'(in_ready), 64'd0);
    do_reset();
    @(negedge clk);
    chk("t6_ready", 64'(in_ready), 64'd3);
    chk("t6_busy", 64'(busy), 64'd0);
    #1 wlog.delete();
    repeat (5) step();
    #1 chk("t6_no_write", 64'(wlog.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
